// File: rtl/mu0_control_pkg.sv
// Shared MU0 control definitions: opcodes, ALU function codes, FSM state codes,
// mux select meanings and the decoded control bundle.
package mu0_defs;

   localparam logic [3:0] OP_LDA = 4'h0;
   localparam logic [3:0] OP_STA = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_JMP = 4'h4;
   localparam logic [3:0] OP_JGE = 4'h5;
   localparam logic [3:0] OP_JNE = 4'h6;
   localparam logic [3:0] OP_STP = 4'h7;

   typedef enum logic [1:0] {
      FS_PASS_Y = 2'b00,
      FS_ADD    = 2'b01,
      FS_INC_X  = 2'b10,
      FS_SUB    = 2'b11
   } alu_fs_e;

   typedef enum logic [1:0] {
      ST_FETCH = 2'b00,
      ST_EXEC  = 2'b01,
      ST_HALT  = 2'b10
   } state_e;

   localparam logic ADDR_PC = 1'b0;
   localparam logic ADDR_IR = 1'b1;
   localparam logic X_PC    = 1'b0;
   localparam logic X_ACC   = 1'b1;
   localparam logic Y_MEM   = 1'b0;
   localparam logic Y_IR    = 1'b1;

   typedef struct packed {
      logic       addr_sel;
      logic       x_sel;
      logic       y_sel;
      logic [1:0] alu_fs;
      logic       pc_en;
      logic       ir_en;
      logic       acc_en;
      logic       mem_rd;
      logic       mem_wr;
      logic       fetch;
      logic       halted;
   } ctrl_t;

   // Opcodes 0..3 touch memory in EXEC and therefore wait for mem_ack.
   function automatic logic is_mem_op(input logic [3:0] f);
      return (f == OP_LDA) || (f == OP_STA) || (f == OP_ADD) || (f == OP_SUB);
   endfunction

endpackage

// File: rtl/mu0_control_decode.sv
// Combinational control decode: current state, opcode, flags and memory
// acknowledge to datapath selects, enables and memory requests.
module mu0_decode
   import mu0_defs::*;
(
   input  logic [1:0] state,
   input  logic [3:0] f,
   input  logic       n,
   input  logic       z,
   input  logic       mem_ack,
   output ctrl_t      ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         ST_FETCH: begin
            ctrl.fetch    = 1'b1;
            ctrl.addr_sel = ADDR_PC;
            ctrl.mem_rd   = 1'b1;
            ctrl.x_sel    = X_PC;
            ctrl.alu_fs   = FS_INC_X;
            ctrl.ir_en    = mem_ack;
            ctrl.pc_en    = mem_ack;
         end
         ST_EXEC: begin
            case (f)
               OP_LDA: begin
                  ctrl.addr_sel = ADDR_IR;
                  ctrl.mem_rd   = 1'b1;
                  ctrl.y_sel    = Y_MEM;
                  ctrl.alu_fs   = FS_PASS_Y;
                  ctrl.acc_en   = mem_ack;
               end
               OP_STA: begin
                  ctrl.addr_sel = ADDR_IR;
                  ctrl.mem_wr   = 1'b1;
                  ctrl.x_sel    = X_ACC;
               end
               OP_ADD, OP_SUB: begin
                  ctrl.addr_sel = ADDR_IR;
                  ctrl.mem_rd   = 1'b1;
                  ctrl.x_sel    = X_ACC;
                  ctrl.y_sel    = Y_MEM;
                  ctrl.alu_fs   = (f == OP_ADD) ? FS_ADD : FS_SUB;
                  ctrl.acc_en   = mem_ack;
               end
               OP_JMP, OP_JGE, OP_JNE: begin
                  ctrl.y_sel  = Y_IR;
                  ctrl.alu_fs = FS_PASS_Y;
                  ctrl.pc_en  = (f == OP_JMP) ? 1'b1 :
                                (f == OP_JGE) ? ~n : ~z;
               end
               default: ;
            endcase
         end
         ST_HALT: ctrl.halted = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/mu0_control.sv
// MU0 fetch/execute sequencer: state register, next-state logic and the
// reset gate on the decoded controls.
//   state    | meaning
//   ST_FETCH | read instruction at PC, load IR, PC+1 on mem_ack
//   ST_EXEC  | execute IR; memory ops wait for mem_ack
//   ST_HALT  | stopped after STP, left only by reset
module mu0_control
   import mu0_defs::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] F,
   input  logic       N,
   input  logic       Z,
   input  logic       mem_ack,
   output logic       addr_sel,
   output logic       x_sel,
   output logic       y_sel,
   output logic [1:0] alu_fs,
   output logic       pc_en,
   output logic       ir_en,
   output logic       acc_en,
   output logic       mem_rd,
   output logic       mem_wr,
   output logic       fetch,
   output logic       halted
);

   state_e state_q, state_d;
   ctrl_t  dec_ctrl;
   ctrl_t  out_ctrl;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_FETCH: if (mem_ack) state_d = ST_EXEC;
         ST_EXEC: begin
            if (F == OP_STP)      state_d = ST_HALT;
            else if (!is_mem_op(F)) state_d = ST_FETCH;
            else if (mem_ack)      state_d = ST_FETCH;
         end
         ST_HALT:  state_d = ST_HALT;
         default:  state_d = ST_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= ST_FETCH;
      else          state_q <= state_d;
   end

   mu0_decode u_decode (
      .state   (state_q),
      .f       (F),
      .n       (N),
      .z       (Z),
      .mem_ack (mem_ack),
      .ctrl    (dec_ctrl)
   );

   // The FETCH read request must not escape while reset is held.
   always_comb begin
      out_ctrl = dec_ctrl;
      if (!reset_n) begin
         out_ctrl       = '0;
         out_ctrl.fetch = 1'b1;
      end
   end

   assign addr_sel = out_ctrl.addr_sel;
   assign x_sel    = out_ctrl.x_sel;
   assign y_sel    = out_ctrl.y_sel;
   assign alu_fs   = out_ctrl.alu_fs;
   assign pc_en    = out_ctrl.pc_en;
   assign ir_en    = out_ctrl.ir_en;
   assign acc_en   = out_ctrl.acc_en;
   assign mem_rd   = out_ctrl.mem_rd;
   assign mem_wr   = out_ctrl.mem_wr;
   assign fetch    = out_ctrl.fetch;
   assign halted   = out_ctrl.halted;

endmodule

// File: tb/tb_mu0_control.sv
// Directed bench for mu0_control: hand-computed control vectors per cycle.
module tb_mu0_control;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [3:0] F;
   logic       N, Z, mem_ack;
   logic       addr_sel, x_sel, y_sel, pc_en, ir_en, acc_en;
   logic       mem_rd, mem_wr, fetch, halted;
   logic [1:0] alu_fs;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   mu0_control dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .F        (F),
      .N        (N),
      .Z        (Z),
      .mem_ack  (mem_ack),
      .addr_sel (addr_sel),
      .x_sel    (x_sel),
      .y_sel    (y_sel),
      .alu_fs   (alu_fs),
      .pc_en    (pc_en),
      .ir_en    (ir_en),
      .acc_en   (acc_en),
      .mem_rd   (mem_rd),
      .mem_wr   (mem_wr),
      .fetch    (fetch),
      .halted   (halted)
   );

   // {addr_sel,x_sel,y_sel,alu_fs,pc_en,ir_en,acc_en,mem_rd,mem_wr,fetch,halted}
   function automatic logic [11:0] mk(input logic a, input logic x, input logic y,
                                      input logic [1:0] fs, input logic pc,
                                      input logic ir, input logic acc, input logic rd,
                                      input logic wr, input logic fe, input logic h);
      return {a, x, y, fs, pc, ir, acc, rd, wr, fe, h};
   endfunction

   task automatic check(input string tag, input logic [11:0] expv);
      logic [11:0] obs;
      obs = {addr_sel, x_sel, y_sel, alu_fs, pc_en, ir_en, acc_en,
             mem_rd, mem_wr, fetch, halted};
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      logic [11:0] fetch_go, fetch_stall, all_zero, halt_v;
      fetch_go    = mk(0,0,0,2'b10,1,1,0,1,0,1,0);
      fetch_stall = mk(0,0,0,2'b10,0,0,0,1,0,1,0);
      all_zero    = 12'h000;
      halt_v      = mk(0,0,0,2'b00,0,0,0,0,0,0,1);

      reset_n = 1'b0; F = 4'h0; N = 1'b0; Z = 1'b0; mem_ack = 1'b1;
      #3;
      check("reset_outputs", mk(0,0,0,2'b00,0,0,0,0,0,1,0));
      tick();
      reset_n = 1'b1;
      #1;

      // LDA 0x005, mem_ack tied high
      F = 4'h0; mem_ack = 1'b1; #1;
      check("lda_fetch", fetch_go);
      tick();
      check("lda_exec", mk(1,0,0,2'b00,0,0,1,1,0,0,0));
      tick();

      // FETCH stall then STA with three EXEC stall cycles
      F = 4'h1; mem_ack = 1'b0; #1;
      check("fetch_stall", fetch_stall);
      tick();
      check("fetch_stall_held", fetch_stall);
      mem_ack = 1'b1; #1;
      check("sta_fetch", fetch_go);
      tick();
      mem_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("sta_stall", mk(1,1,0,2'b00,0,0,0,0,1,0,0));
         tick();
      end
      mem_ack = 1'b1; #1;
      check("sta_ack", mk(1,1,0,2'b00,0,0,0,0,1,0,0));
      tick();

      // JGE taken / not taken
      F = 4'h5; N = 1'b1; #1;
      check("jge_fetch", fetch_go);
      tick();
      check("jge_n1", mk(0,0,1,2'b00,0,0,0,0,0,0,0));
      tick();
      N = 1'b0; #1;
      check("jge_refetch", fetch_go);
      tick();
      check("jge_n0", mk(0,0,1,2'b00,1,0,0,0,0,0,0));
      tick();

      // JNE with Z=1 then Z=0
      F = 4'h6; Z = 1'b1; #1;
      check("jne_fetch", fetch_go);
      tick();
      check("jne_z1", mk(0,0,1,2'b00,0,0,0,0,0,0,0));
      tick();
      Z = 1'b0; #1;
      check("jne_refetch", fetch_go);
      tick();
      check("jne_z0", mk(0,0,1,2'b00,1,0,0,0,0,0,0));
      tick();

      // JMP
      F = 4'h4; Z = 1'b1; N = 1'b1; #1;
      check("jmp_fetch", fetch_go);
      tick();
      check("jmp_exec", mk(0,0,1,2'b00,1,0,0,0,0,0,0));
      tick();

      // NOP 0xA with spurious ack
      F = 4'hA; #1;
      check("nop_fetch", fetch_go);
      tick();
      check("nop_exec", all_zero);
      tick();
      mem_ack = 1'b0; #1;
      check("nop_back_fetch", fetch_stall);
      mem_ack = 1'b1;

      // SUB and ADD single cycle exec
      F = 4'h3; #1;
      tick();
      check("sub_exec", mk(1,1,0,2'b11,0,0,1,1,0,0,0));
      tick();
      F = 4'h2; #1;
      check("add_fetch", fetch_go);
      tick();
      check("add_exec", mk(1,1,0,2'b01,0,0,1,1,0,0,0));
      tick();

      // Async reset in the middle of a stalled ADD
      tick();
      mem_ack = 1'b0; #1;
      check("add_stall", mk(1,1,0,2'b01,0,0,0,1,0,0,0));
      #1 reset_n = 1'b0;
      #1;
      check("reset_mid_add", mk(0,0,0,2'b00,0,0,0,0,0,1,0));
      #1 reset_n = 1'b1;
      #1;
      check("release_fetch", fetch_stall);
      tick();
      check("release_fetch_held", fetch_stall);

      // STP then absorbing HALT
      F = 4'h7; mem_ack = 1'b1; #1;
      check("stp_fetch", fetch_go);
      tick();
      check("stp_exec", all_zero);
      tick();
      for (int i = 0; i < 20; i++) begin
         mem_ack = i[0];
         F = 4'(i);
         #1;
         check("halt_hold", halt_v);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
